// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: NZVC flag
// positions and the sequencer state encoding.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Runs a wide (4*NIBBLES-bit) operation through an external 4-bit ALU,
// one nibble per cycle, least-significant nibble first. The carry is
// chained between nibbles and the per-nibble flags are merged into wide
// NZVC flags.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a request; operands are latched on acceptance
//   RUN   | one nibble per cycle through the ALU, idx selects the nibble
//   DONE  | wide result/flags presented, waiting for rsp_ready
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int  NIBBLES = 2,
    parameter int  IDX_W   = $clog2(NIBBLES),
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [2:0]   req_op,
    input  logic         req_bank,
    input  logic         req_cin,

    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_bank,
    output logic         alu_cin,
    input  logic [3:0]   alu_result,
    input  logic [3:0]   alu_flags,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_lat;
    logic [W-1:0]     b_lat;
    logic [W-1:0]     work;
    logic [W-1:0]     work_nxt;
    logic [W-1:0]     res_q;
    logic [3:0]       flags_q;
    logic [2:0]       op_lat;
    logic             bank_lat;
    logic             carry;
    logic             z_acc;
    logic             z_final;
    logic             accept;
    logic             step;
    logic             last;

    assign accept  = (state == IDLE) && req_valid;
    assign step    = (state == RUN);
    assign last    = step && (idx == IDX_W'(NIBBLES - 1));
    assign z_final = z_acc & alu_flags[FLAG_Z];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select the current operand nibbles and merge the ALU result into the
    // working word; a mux over idx keeps the slice widths static.
    always_comb begin
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        work_nxt = work;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                alu_a               = a_lat[4*i +: 4];
                alu_b               = b_lat[4*i +: 4];
                work_nxt[4*i +: 4]  = alu_result;
            end
        end
    end

    assign alu_op     = op_lat;
    assign alu_bank   = bank_lat;
    assign alu_cin    = carry;
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;

    // Operand latch, nibble stepping, carry/Z chaining and response capture.
    // The response registers only change at completion so a consumer sees
    // stable data until the next operation finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            op_lat   <= 3'd0;
            bank_lat <= 1'b0;
            carry    <= 1'b0;
            z_acc    <= 1'b0;
            work     <= '0;
            res_q    <= '0;
            flags_q  <= 4'h0;
        end else if (accept) begin
            a_lat    <= req_a;
            b_lat    <= req_b;
            op_lat   <= req_op;
            bank_lat <= req_bank;
            carry    <= req_cin;
            idx      <= '0;
            z_acc    <= 1'b1;
        end else if (step) begin
            work  <= work_nxt;
            carry <= alu_flags[FLAG_C];
            z_acc <= z_final;
            if (last) begin
                res_q           <= work_nxt;
                flags_q[FLAG_N] <= alu_flags[FLAG_N];
                flags_q[FLAG_Z] <= z_final;
                flags_q[FLAG_V] <= alu_flags[FLAG_V];
                flags_q[FLAG_C] <= alu_flags[FLAG_C];
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end else if ((state == DONE) && rsp_ready) begin
            idx <= '0;
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a 4-bit adder stub stands in for the ROM
// ALU; a wide-add reference model tracks the NIBBLES=2 instance every cycle,
// directed vectors pin literal results, and one NIBBLES=4 instance is
// exercised directly.
module tb_alu_nibble_sequencer;

    localparam int N2 = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // NIBBLES=2 instance
    logic       req_valid, req_ready, req_bank, req_cin;
    logic [7:0] req_a, req_b;
    logic [2:0] req_op, alu_op;
    logic [3:0] alu_a, alu_b, alu_result, alu_flags, rsp_flags;
    logic       alu_bank, alu_cin, rsp_valid, rsp_ready;
    logic [7:0] rsp_result;

    // NIBBLES=4 instance
    logic        req_valid4, req_ready4, req_bank4, req_cin4;
    logic [15:0] req_a4, req_b4;
    logic [2:0]  req_op4, alu_op4;
    logic [3:0]  alu_a4, alu_b4, alu_result4, alu_flags4, rsp_flags4;
    logic        alu_bank4, alu_cin4, rsp_valid4, rsp_ready4;
    logic [15:0] rsp_result4;

    // 4-bit adder stub: returns {N, Z, V, C, result}
    function automatic logic [7:0] stub_alu(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        r = s[3:0];
        return {r[3], (r == 4'h0), ((a[3] == b[3]) && (r[3] != a[3])), s[4], r};
    endfunction

    assign {alu_flags, alu_result}   = stub_alu(alu_a, alu_b, alu_cin);
    assign {alu_flags4, alu_result4} = stub_alu(alu_a4, alu_b4, alu_cin4);

    alu_nibble_sequencer #(.NIBBLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_bank(req_bank), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_bank(alu_bank), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    alu_nibble_sequencer #(.NIBBLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4), .req_b(req_b4),
        .req_op(req_op4), .req_bank(req_bank4), .req_cin(req_cin4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_bank(alu_bank4), .alu_cin(alu_cin4),
        .alu_result(alu_result4), .alu_flags(alu_flags4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4), .rsp_flags(rsp_flags4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (NIBBLES=2 instance) ----------------
    // Wide result of a plain W-bit add: {N, Z, V, C, result}
    function automatic logic [11:0] wide_add(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin);
        int         s;
        logic [7:0] r;
        s = int'(a) + int'(b) + int'(cin);
        r = s[7:0];
        return {r[7], (r == 8'h00), ((a[7] == b[7]) && (r[7] != a[7])), s[8], r};
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] v, input int k);
        return 4'(v >> (4 * k));
    endfunction

    // Carry that must enter nibble k of a + b + cin
    function automatic logic carry_into(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input int k);
        int mask;
        int s;
        mask = (1 << (4 * k)) - 1;
        s = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
        return 1'((s >> (4 * k)) & 1);
    endfunction

    bit         m_busy = 1'b0;
    int         m_age = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;
    logic       m_cin = 1'b0, m_bank = 1'b0;
    logic [2:0] m_op = 3'd0;
    logic [3:0] m_flags = 4'h0;

    // m_age counts cycles since acceptance; the response is due once
    // N2 nibbles have been processed, and the sequencer only frees up on
    // the handshake edge, so the next accept lands one edge later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_res   = 8'h00;
            m_flags = 4'h0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_a    = req_a;
                m_b    = req_b;
                m_cin  = req_cin;
                m_op   = req_op;
                m_bank = req_bank;
            end
        end else if (m_age == N2) begin
            if (rsp_ready) m_busy = 1'b0;
        end else begin
            m_age++;
            if (m_age == N2) {m_flags, m_res} = wide_add(m_a, m_b, m_cin);
        end
    end

    // Per-cycle comparison of the NIBBLES=2 instance against the model
    always @(negedge clk) begin
        if (reset_n) begin
            chk("req_ready", req_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy && (m_age == N2));
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", rsp_flags, m_flags);
            if (m_busy && (m_age < N2)) begin
                chk("alu_a", alu_a, nib(m_a, m_age));
                chk("alu_b", alu_b, nib(m_b, m_age));
                chk("alu_cin", alu_cin, carry_into(m_a, m_b, m_cin, m_age));
                chk("alu_op", alu_op, m_op);
                chk("alu_bank", alu_bank, m_bank);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [2:0] op, input logic bank);
        int n;
        n = 0;
        req_a = a; req_b = b; req_cin = cin; req_op = op; req_bank = bank;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", (n < 20), 1);
        @(posedge clk);
        #1;
        // scramble the request inputs: the in-flight op must not notice
        req_valid = 1'b0;
        req_a = ~a; req_b = 8'h5C; req_cin = ~cin; req_op = ~op; req_bank = ~bank;
    endtask

    task automatic wait_rsp(output int lat, output logic cin2);
        lat = 0;
        cin2 = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) cin2 = alu_cin;
        end while (!rsp_valid && lat < 30);
        chk("rsp_in_time", (lat < 30), 1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic cin2;

        req_valid = 0; req_a = 0; req_b = 0; req_op = 0; req_bank = 0; req_cin = 0; rsp_ready = 0;
        req_valid4 = 0; req_a4 = 0; req_b4 = 0; req_op4 = 0; req_bank4 = 0; req_cin4 = 0; rsp_ready4 = 0;

        // reset values
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 8'h00);
        chk("rst_rsp_flags", rsp_flags, 4'h0);
        chk("rst_alu_a", alu_a, 4'h0);
        chk("rst_alu_cin", alu_cin, 0);
        chk("rst4_req_ready", req_ready4, 1);
        chk("rst4_rsp_valid", rsp_valid4, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // 0x3A + 0x47 -> 0x81, N=1 Z=0 V=1 C=0, response in the 3rd cycle
        send_req(8'h3A, 8'h47, 1'b0, 3'd5, 1'b1);
        wait_rsp(lat, cin2);
        chk("t1_latency", lat, 3);
        chk("t1_result", rsp_result, 8'h81);
        chk("t1_flags", rsp_flags, 4'b1010);
        ack_rsp();

        // 0xFF + 0x01 -> 0x00, Z=1 C=1; carry into the high nibble
        send_req(8'hFF, 8'h01, 1'b0, 3'd0, 1'b0);
        wait_rsp(lat, cin2);
        chk("t2_cin_nibble1", cin2, 1);
        chk("t2_result", rsp_result, 8'h00);
        chk("t2_flags", rsp_flags, 4'b0101);
        ack_rsp();

        // 0x10 + 0x00 -> 0x10, low nibble zero but wide Z must be 0
        send_req(8'h10, 8'h00, 1'b0, 3'd1, 1'b0);
        wait_rsp(lat, cin2);
        chk("t3_result", rsp_result, 8'h10);
        chk("t3_flags", rsp_flags, 4'b0000);
        ack_rsp();

        // backpressure with a held follow-on request
        send_req(8'h12, 8'h34, 1'b0, 3'd2, 1'b0);
        wait_rsp(lat, cin2);
        chk("t4_result", rsp_result, 8'h46);
        req_a = 8'h01; req_b = 8'h02; req_cin = 1'b0; req_op = 3'd3; req_bank = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_result", rsp_result, 8'h46);
            chk("t4_hold_ready", req_ready, 0);
        end
        ack_rsp();
        chk("t4_idle_ready", req_ready, 1);
        chk("t4_idle_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("t4_accepted", req_ready, 0);
        req_valid = 1'b0;
        wait_rsp(lat, cin2);
        chk("t4b_latency", lat, 3);
        chk("t4b_result", rsp_result, 8'h03);
        ack_rsp();

        // reset in the middle of RUN (idx=1)
        send_req(8'h55, 8'h22, 1'b0, 3'd4, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_req_ready", req_ready, 1);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_alu_a", alu_a, 4'h0);
        chk("t5_alu_b", alu_b, 4'h0);
        chk("t5_alu_op", alu_op, 3'd0);
        chk("t5_alu_bank", alu_bank, 0);
        chk("t5_rsp_result", rsp_result, 8'h00);
        @(negedge clk);
        #1 reset_n = 1'b1;
        send_req(8'h01, 8'h01, 1'b0, 3'd0, 1'b0);
        wait_rsp(lat, cin2);
        chk("t5_result", rsp_result, 8'h02);
        chk("t5_flags", rsp_flags, 4'b0000);
        ack_rsp();

        // NIBBLES=4: 0x7FFF + 0x0001 -> 0x8000, N=1 V=1, response in 5th cycle
        @(negedge clk);
        req_a4 = 16'h7FFF; req_b4 = 16'h0001; req_cin4 = 1'b0; req_op4 = 3'd0; req_bank4 = 1'b0;
        req_valid4 = 1'b1;
        chk("t6_ready", req_ready4, 1);
        @(posedge clk);
        #1;
        req_valid4 = 1'b0;
        req_a4 = 16'h0000;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid4 && lat < 30);
        chk("t6_latency", lat, 5);
        chk("t6_result", rsp_result4, 16'h8000);
        chk("t6_flags", rsp_flags4, 4'b1010);
        rsp_ready4 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready4 = 1'b0;
        chk("t6_idle_ready", req_ready4, 1);
        chk("t6_result_held", rsp_result4, 16'h8000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
